// File: rtl/task_submit_queue.sv
`default_nettype none
// =============================================================================
// Module   : task_submit_queue
// Brief    : Debounced submit key captures switch task ID/burst into a small
//            FIFO offered on a valid/ready port. Optional build macro
//            TSQ_DUP_REJECT_EN rejects duplicate queued IDs and adds o_err_dup.
// Revision : 1.0 - initial release
// =============================================================================
module task_submit_queue #(
  parameter int DEPTH     = 4,
  parameter int ID_W      = 4,
  parameter int TIME_W    = 4,
  parameter int DB_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [ID_W-1:0]            i_sw_task_id,
  input  logic [TIME_W-1:0]          i_sw_burst,
  input  logic                       i_key_submit_n,
  input  logic                       i_key_flush_n,
  output logic                       o_req_valid,
  output logic [ID_W-1:0]            o_req_task_id,
  output logic [TIME_W-1:0]          o_req_burst,
  input  logic                       i_req_ready,
  output logic [$clog2(DEPTH+1)-1:0] o_q_count,
  output logic                       o_q_full,
  output logic                       o_err_overflow,
`ifdef TSQ_DUP_REJECT_EN
  output logic                       o_err_dup,
`endif
  output logic                       o_err_zero
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int DBC_W = $clog2(DB_CYCLES+1);

  typedef enum logic [1:0] {
    S_RELEASED  = 2'd0,
    S_PRESSING  = 2'd1,
    S_PRESSED   = 2'd2,
    S_RELEASING = 2'd3
  } db_state_t;

  logic              r_sub_s1, r_sub_s2;
  logic              r_fl_s1, r_fl_s2;
  logic [ID_W-1:0]   r_id_s1, r_id_s2;
  logic [TIME_W-1:0] r_bt_s1, r_bt_s2;

  db_state_t         r_db_state;
  logic [DBC_W-1:0]  r_db_cnt;
  logic              r_push_stb;

  logic [ID_W-1:0]   r_mem_id [DEPTH];
  logic [TIME_W-1:0] r_mem_bt [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_err_ovf, r_err_zero;

  logic w_flush, w_pop, w_full, w_zero, w_dup, w_ovf, w_push;

  // Keys reset to the released (high) level so a held key must debounce anew
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sub_s1 <= 1'b1;
      r_sub_s2 <= 1'b1;
      r_fl_s1  <= 1'b1;
      r_fl_s2  <= 1'b1;
      r_id_s1  <= '0;
      r_id_s2  <= '0;
      r_bt_s1  <= '0;
      r_bt_s2  <= '0;
    end else begin
      r_sub_s1 <= i_key_submit_n;
      r_sub_s2 <= r_sub_s1;
      r_fl_s1  <= i_key_flush_n;
      r_fl_s2  <= r_fl_s1;
      r_id_s1  <= i_sw_task_id;
      r_id_s2  <= r_id_s1;
      r_bt_s1  <= i_sw_burst;
      r_bt_s2  <= r_bt_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_db_state <= S_RELEASED;
      r_db_cnt   <= '0;
      r_push_stb <= 1'b0;
    end else begin
      r_push_stb <= 1'b0;
      case (r_db_state)
        S_RELEASED: begin
          if (!r_sub_s2) begin
            r_db_state <= S_PRESSING;
            r_db_cnt   <= DBC_W'(1);
          end
        end
        S_PRESSING: begin
          if (r_sub_s2) begin
            r_db_state <= S_RELEASED;
          end else if (r_db_cnt == DBC_W'(DB_CYCLES-1)) begin
            r_db_state <= S_PRESSED;
            r_push_stb <= 1'b1;
          end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
          end
        end
        S_PRESSED: begin
          if (r_sub_s2) begin
            r_db_state <= S_RELEASING;
            r_db_cnt   <= DBC_W'(1);
          end
        end
        S_RELEASING: begin
          if (!r_sub_s2) begin
            r_db_state <= S_PRESSED;
          end else if (r_db_cnt == DBC_W'(DB_CYCLES-1)) begin
            r_db_state <= S_RELEASED;
          end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
          end
        end
        default: r_db_state <= S_RELEASED;
      endcase
    end
  end

  assign w_flush = !r_fl_s2;
  assign w_pop   = (r_count != '0) && i_req_ready && !w_flush;
  assign w_full  = (r_count == CNT_W'(DEPTH));

`ifdef TSQ_DUP_REJECT_EN
  logic [DEPTH-1:0] w_dup_hit;
  logic             r_err_dup;

  // Slot g is live when its distance from the head is below the count; the
  // head slot leaving this cycle no longer blocks a matching push.
  for (genvar g = 0; g < DEPTH; g++) begin : g_dup
    logic [PTR_W-1:0] w_off;
    assign w_off        = PTR_W'(g) - r_rd_ptr;
    assign w_dup_hit[g] = (CNT_W'(w_off) < r_count) && !(w_pop && (w_off == '0)) &&
                          (r_mem_id[g] == r_id_s2);
  end
  assign w_dup = |w_dup_hit;
`else
  assign w_dup = 1'b0;
`endif

  // Burst check first, then duplicate, then capacity
  assign w_zero = r_push_stb && !w_flush && (r_bt_s2 == '0);
  assign w_ovf  = r_push_stb && !w_flush && !w_zero && !w_dup && w_full && !w_pop;
  assign w_push = r_push_stb && !w_flush && !w_zero && !w_dup && !(w_full && !w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_id[i] <= '0;
        r_mem_bt[i] <= '0;
      end
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_err_ovf <= 1'b0;
    end else if (w_flush) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_err_ovf <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem_id[r_wr_ptr] <= r_id_s2;
        r_mem_bt[r_wr_ptr] <= r_bt_s2;
        r_wr_ptr           <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
      if (w_ovf) begin
        r_err_ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_zero <= 1'b0;
    end else if (w_zero) begin
      r_err_zero <= 1'b1;
    end else if (w_push) begin
      r_err_zero <= 1'b0;
    end
  end

`ifdef TSQ_DUP_REJECT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_dup <= 1'b0;
    end else if (w_flush) begin
      r_err_dup <= 1'b0;
    end else if (r_push_stb && !w_zero && w_dup) begin
      r_err_dup <= 1'b1;
    end
  end
  assign o_err_dup = r_err_dup;
`endif

  assign o_req_valid    = (r_count != '0);
  assign o_req_task_id  = r_mem_id[r_rd_ptr];
  assign o_req_burst    = r_mem_bt[r_rd_ptr];
  assign o_q_count      = r_count;
  assign o_q_full       = w_full;
  assign o_err_overflow = r_err_ovf;
  assign o_err_zero     = r_err_zero;

endmodule
`default_nettype wire
